// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_1bit.sv
// Combinational 1-bit full-subtractor cell: Diff = A - B - Bin, with borrow out.
module subtractor_1bit (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic a_n;
  logic ab_x;

  assign a_n  = ~A;
  assign ab_x = A ^ B;
  assign Diff = ab_x ^ Bin;
  // Borrow when B exceeds A, or when A equals B and a borrow is already pending.
  assign Bout = (a_n & B) | (~ab_x & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, with start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] count;
  logic             bw;
  logic             a_sign;
  logic             b_sign;

  logic             d_bit;
  logic             bw_next;
  logic [WIDTH-1:0] res_next;

  subtractor_1bit u_cell (
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .Bin (bw),
    .Diff(d_bit),
    .Bout(bw_next)
  );

  // New difference bit enters from the MSB side so the LSB ends up at bit 0.
  always_comb begin
    res_next           = res_sr >> 1;
    res_next[WIDTH-1]  = d_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      count      <= '0;
      bw         <= 1'b0;
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            res_sr <= '0;
            count  <= '0;
            bw     <= 1'b0;
            a_sign <= a_in[WIDTH-1];
            b_sign <= b_in[WIDTH-1];
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          bw     <= bw_next;
          count  <= count + 1'b1;
          // Results are published from the final bit's combinational values.
          if (count == CNT_LAST) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= bw_next;
            ovf        <= (a_sign != b_sign) && (res_next[WIDTH-1] != a_sign);
            state      <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances against a behavioural model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       st [2];
  logic [7:0] av [2];
  logic [7:0] bv [2];

  logic       busy_w [2];
  logic       done_w [2];
  logic       bor_w  [2];
  logic       ovf_w  [2];
  logic [7:0] diff8;
  logic [0:0] diff1;
  logic [0:0] a1_w;
  logic [0:0] b1_w;

  int checks;
  int failures;
  logic chk_en;

  assign a1_w = av[1][0:0];
  assign b1_w = bv[1][0:0];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (st[0]),
    .a_in      (av[0]),
    .b_in      (bv[0]),
    .busy      (busy_w[0]),
    .done      (done_w[0]),
    .diff      (diff8),
    .borrow_out(bor_w[0]),
    .ovf       (ovf_w[0])
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (st[1]),
    .a_in      (a1_w),
    .b_in      (b1_w),
    .busy      (busy_w[1]),
    .done      (done_w[1]),
    .diff      (diff1),
    .borrow_out(bor_w[1]),
    .ovf       (ovf_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: cycles remaining in the operation plus the arithmetic result.
  int widths [2];
  int m_cnt  [2];
  int m_done [2];
  int m_diff [2];
  int m_bor  [2];
  int m_ovf  [2];
  int p_diff [2];
  int p_bor  [2];
  int p_ovf  [2];

  initial begin
    widths[0] = 8;
    widths[1] = 1;
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i]  = 0;
        m_done[i] = 0;
        m_diff[i] = 0;
        m_bor[i]  = 0;
        m_ovf[i]  = 0;
      end else if (m_cnt[i] == 0) begin
        m_done[i] = 0;
        if (st[i]) begin
          int w, mask, a, b, sa, sb, r;
          w    = widths[i];
          mask = (1 << w) - 1;
          a    = int'(av[i]) & mask;
          b    = int'(bv[i]) & mask;
          sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
          sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
          r    = sa - sb;
          p_diff[i] = (a - b) & mask;
          p_bor[i]  = (a < b) ? 1 : 0;
          p_ovf[i]  = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
          m_cnt[i]  = w;
        end
      end else begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          m_done[i] = 1;
          m_diff[i] = p_diff[i];
          m_bor[i]  = p_bor[i];
          m_ovf[i]  = p_ovf[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("w8 busy", int'(busy_w[0]), (m_cnt[0] > 0) ? 1 : 0);
      check("w8 done", int'(done_w[0]), m_done[0]);
      check("w8 diff", int'(diff8), m_diff[0]);
      check("w8 borrow_out", int'(bor_w[0]), m_bor[0]);
      check("w8 ovf", int'(ovf_w[0]), m_ovf[0]);
      check("w1 busy", int'(busy_w[1]), (m_cnt[1] > 0) ? 1 : 0);
      check("w1 done", int'(done_w[1]), m_done[1]);
      check("w1 diff", int'(diff1), m_diff[1]);
      check("w1 borrow_out", int'(bor_w[1]), m_bor[1]);
      check("w1 ovf", int'(ovf_w[1]), m_ovf[1]);
      check("busy and done exclusive", int'(busy_w[0] & done_w[0]) + int'(busy_w[1] & done_w[1]), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called just after the accepting edge; returns edges until done and busy cycles seen.
  task automatic wait_done(input int idx, output int edges, output int nbusy);
    edges = 0;
    nbusy = 0;
    while (!done_w[idx] && edges < 40) begin
      if (busy_w[idx]) nbusy++;
      tick(1);
      edges++;
    end
    if (!done_w[idx]) check("done timeout", 0, 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int exp_diff,
                     input int exp_bor, input int exp_ovf);
    int edges, nbusy;
    av[0] = a;
    bv[0] = b;
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    wait_done(0, edges, nbusy);
    check("op8 latency", edges, 8);
    check("op8 busy cycles", nbusy, 8);
    check("op8 diff literal", int'(diff8), exp_diff);
    check("op8 borrow literal", int'(bor_w[0]), exp_bor);
    check("op8 ovf literal", int'(ovf_w[0]), exp_ovf);
  endtask

  initial begin
    int edges, nbusy, ndone;
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      av[i] = '0;
      bv[i] = '0;
    end
    tick(2);
    chk_en = 1'b1;
    check("reset diff", int'(diff8), 0);
    check("reset busy", int'(busy_w[0]), 0);
    check("reset done", int'(done_w[0]), 0);
    rst = 1'b0;
    tick(1);

    op8(8'h5A, 8'h23, 8'h37, 0, 0);
    tick(1);
    op8(8'h10, 8'h20, 8'hF0, 1, 0);
    op8(8'h80, 8'h01, 8'h7F, 0, 1);
    tick(2);

    // Stray start during SHIFT must be ignored.
    av[0] = 8'h05;
    bv[0] = 8'h03;
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(2);
    av[0] = 8'hFF;
    bv[0] = 8'hFF;
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    wait_done(0, edges, nbusy);
    check("ignored start latency", edges, 5);
    check("ignored start diff", int'(diff8), 8'h02);
    ndone = 0;
    repeat (12) begin
      tick(1);
      if (done_w[0]) ndone++;
    end
    check("single done pulse", ndone, 0);

    // Start held high: back-to-back operations.
    av[0] = 8'h00;
    bv[0] = 8'h01;
    st[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      wait_done(0, edges, nbusy);
      check("b2b latency", edges, 8);
      check("b2b diff", int'(diff8), 8'hFF);
      check("b2b borrow", int'(bor_w[0]), 1);
    end
    st[0] = 1'b0;
    tick(2);

    // Reset mid-operation.
    av[0] = 8'h77;
    bv[0] = 8'h11;
    st[0] = 1'b1;
    tick(1);
    st[0] = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    check("mid reset diff", int'(diff8), 0);
    check("mid reset busy", int'(busy_w[0]), 0);
    check("mid reset borrow", int'(bor_w[0]), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    op8(8'h33, 8'h11, 8'h22, 0, 0);
    tick(2);

    // WIDTH=1 instance.
    av[1] = 8'h00;
    bv[1] = 8'h01;
    st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0;
    wait_done(1, edges, nbusy);
    check("w1 latency", edges, 1);
    check("w1 busy cycles", nbusy, 1);
    check("w1 diff literal", int'(diff1), 1);
    check("w1 borrow literal", int'(bor_w[1]), 1);
    check("w1 ovf literal", int'(ovf_w[1]), 1);
    tick(2);

    // Randomized traffic on both instances, checked cycle by cycle by the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 3) != 0);
        av[i] = 8'($urandom_range(0, 255));
        bv[i] = 8'($urandom_range(0, 255));
      end
      if (n % 8 == 0) begin
        av[0] = 8'h80;
        bv[0] = 8'($urandom_range(0, 1) != 0 ? 8'h7F : 8'h80);
      end
      tick(1);
    end
    st[0] = 1'b0;
    st[1] = 1'b0;
    tick(12);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
